// File: rtl/load_store_unit.sv
// Load/store unit: turns one execute-stage request into a single word-wide
// memory transaction with byte enables, lane-replicated write data, load
// extraction with sign/zero extension, misalignment/illegal checks and an
// ACCESS timeout.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             request strobe (accepted only when idle)
//   is_store, funct3  operation (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   addr, store_data  effective address and store value
//   busy, done, err   status; done is a one-cycle pulse, err valid with done
//   load_data         extended load result, held between completions
//   mem_req/we/addr/be/wdata  memory request side
//   mem_ack, mem_rdata        memory response side
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic [1:0]  err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  localparam logic [1:0] E_OK  = 2'b00;
  localparam logic [1:0] E_MIS = 2'b01;
  localparam logic [1:0] E_TO  = 2'b10;
  localparam logic [1:0] E_ILL = 2'b11;

  logic [1:0]       state, state_n;
  logic             pend, pend_n;
  logic [1:0]       err_pend, err_pend_n;
  logic             op_store, op_store_n;
  logic [2:0]       op_f3, op_f3_n;
  logic [1:0]       op_lane, op_lane_n;
  logic [CNT_W-1:0] cnt, cnt_n;

  logic        busy_n, done_n, mem_req_n, mem_we_n;
  logic [1:0]  err_n;
  logic [3:0]  mem_be_n;
  logic [31:0] load_data_n, mem_addr_n, mem_wdata_n;

  // Request decode, evaluated on the raw inputs at the accepting edge
  logic [1:0]  dec_err;
  logic [3:0]  dec_be;
  logic [31:0] dec_wdata;

  always_comb begin
    dec_err   = E_OK;
    dec_be    = 4'b0000;
    dec_wdata = store_data;
    if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111 ||
        (is_store && funct3[2])) begin
      dec_err = E_ILL;
    end else if ((funct3[1:0] == 2'b01 && addr[0]) ||
                 (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00)) begin
      dec_err = E_MIS;
    end
    case (funct3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << addr[1:0];
        dec_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        dec_be    = addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{store_data[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = store_data;
      end
    endcase
  end

  // Load extraction from the returned word using the captured lane
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    rd_byte = 8'h00;
    rd_half = op_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    rd_ext  = mem_rdata;
    case (op_lane)
      2'd0:    rd_byte = mem_rdata[7:0];
      2'd1:    rd_byte = mem_rdata[15:8];
      2'd2:    rd_byte = mem_rdata[23:16];
      default: rd_byte = mem_rdata[31:24];
    endcase
    case (op_f3[1:0])
      2'b00:   rd_ext = op_f3[2] ? {24'h000000, rd_byte}
                                 : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   rd_ext = op_f3[2] ? {16'h0000, rd_half}
                                 : {{16{rd_half[15]}}, rd_half};
      default: rd_ext = mem_rdata;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    pend_n      = pend;
    err_pend_n  = err_pend;
    op_store_n  = op_store;
    op_f3_n     = op_f3;
    op_lane_n   = op_lane;
    cnt_n       = cnt;
    busy_n      = busy;
    done_n      = 1'b0;
    err_n       = E_OK;
    load_data_n = load_data;
    mem_req_n   = mem_req;
    mem_we_n    = mem_we;
    mem_addr_n  = mem_addr;
    mem_be_n    = mem_be;
    mem_wdata_n = mem_wdata;

    case (state)
      S_IDLE: begin
        if (pend) begin
          // Rejected request: one decode cycle so done lines up with the
          // fastest memory completion, then report without touching memory
          pend_n      = 1'b0;
          state_n     = S_DONE;
          busy_n      = 1'b1;
          done_n      = 1'b1;
          err_n       = err_pend;
          load_data_n = 32'h0;
        end else if (start) begin
          op_store_n = is_store;
          op_f3_n    = funct3;
          op_lane_n  = addr[1:0];
          if (dec_err != E_OK) begin
            pend_n     = 1'b1;
            err_pend_n = dec_err;
          end else begin
            state_n     = S_ACCESS;
            busy_n      = 1'b1;
            cnt_n       = CNT_W'(1);
            mem_req_n   = 1'b1;
            mem_we_n    = is_store;
            mem_addr_n  = {addr[31:2], 2'b00};
            mem_be_n    = dec_be;
            mem_wdata_n = dec_wdata;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack || cnt == CNT_W'(TIMEOUT)) begin
          state_n     = S_DONE;
          done_n      = 1'b1;
          cnt_n       = '0;
          mem_req_n   = 1'b0;
          mem_we_n    = 1'b0;
          mem_be_n    = 4'b0000;
          if (mem_ack) begin
            load_data_n = op_store ? 32'h0 : rd_ext;
          end else begin
            err_n       = E_TO;
            load_data_n = 32'h0;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        busy_n  = 1'b0;
      end
      default: begin
        state_n   = S_IDLE;
        busy_n    = 1'b0;
        mem_req_n = 1'b0;
        mem_we_n  = 1'b0;
        mem_be_n  = 4'b0000;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pend      <= 1'b0;
      err_pend  <= E_OK;
      op_store  <= 1'b0;
      op_f3     <= 3'b000;
      op_lane   <= 2'b00;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= E_OK;
      load_data <= 32'h0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
    end else begin
      state     <= state_n;
      pend      <= pend_n;
      err_pend  <= err_pend_n;
      op_store  <= op_store_n;
      op_f3     <= op_f3_n;
      op_lane   <= op_lane_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
      err       <= err_n;
      load_data <= load_data_n;
      mem_req   <= mem_req_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_be    <= mem_be_n;
      mem_wdata <= mem_wdata_n;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed transactions
// plus hand-written timeout, reset-abort and stray-ack sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic [1:0]  err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  load_store_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data),
    .busy(busy), .done(done), .load_data(load_data), .err(err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    logic [1:0]  xerr;
    logic [31:0] xaddr;
    logic [3:0]  xbe;
    logic [31:0] xwd;
    logic [31:0] xld;
  } vec_t;

  vec_t vec[14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start      = 1'b0;
    is_store   = 1'b0;
    funct3     = 3'b000;
    addr       = 32'hFFFF_FFFF;
    store_data = 32'h5555_5555;
  endtask

  initial begin
    //        st  f3      addr          sdata         rdata         dly err    xaddr         xbe      xwdata        xld
    vec[0]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, 2'b00, 32'h0000_0100, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vec[1]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h0,        0, 2'b00, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 32'h0};
    vec[2]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,        32'h80FF_1234, 2, 2'b00, 32'h0000_0100, 4'b0010, 32'h0,        32'h0000_0012};
    vec[3]  = '{1'b0, 3'b001, 32'h0000_0002, 32'h0,        32'h80FF_1234, 0, 2'b00, 32'h0000_0000, 4'b1100, 32'h0,        32'hFFFF_80FF};
    vec[4]  = '{1'b0, 3'b101, 32'h0000_0000, 32'h0,        32'h80FF_1234, 1, 2'b00, 32'h0000_0000, 4'b0011, 32'h0,        32'h0000_1234};
    vec[5]  = '{1'b0, 3'b010, 32'h0000_0004, 32'h0,        32'hDEAD_BEEF, 1, 2'b00, 32'h0000_0004, 4'b1111, 32'h0,        32'hDEAD_BEEF};
    vec[6]  = '{1'b1, 3'b000, 32'h0000_0001, 32'h1234_56A5, 32'h0,        0, 2'b00, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 32'h0};
    vec[7]  = '{1'b1, 3'b010, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,        3, 2'b00, 32'h0000_0008, 4'b1111, 32'hCAFE_F00D, 32'h0};
    vec[8]  = '{1'b0, 3'b000, 32'h0000_0082, 32'h0,        32'h7F00_0000, 0, 2'b00, 32'h0000_0080, 4'b0100, 32'h0,        32'h0000_0000};
    vec[9]  = '{1'b0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_7FFF, 0, 2'b00, 32'h0000_0000, 4'b0011, 32'h0,        32'h0000_7FFF};
    vec[10] = '{1'b0, 3'b010, 32'h0000_0006, 32'h0,        32'h0,        0, 2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};
    vec[11] = '{1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h0,        0, 2'b11, 32'h0,         4'b0000, 32'h0,        32'h0};
    vec[12] = '{1'b1, 3'b100, 32'h0000_0000, 32'h0,        32'h0,        0, 2'b11, 32'h0,         4'b0000, 32'h0,        32'h0};
    vec[13] = '{1'b0, 3'b001, 32'h0000_0003, 32'h0,        32'h0,        0, 2'b01, 32'h0,         4'b0000, 32'h0,        32'h0};

    rst       = 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    idle_inputs();
    start = 1'b1;
    tick();
    tick();
    chk("rst_busy",  32'(busy),    32'h0);
    chk("rst_done",  32'(done),    32'h0);
    chk("rst_req",   32'(mem_req), 32'h0);
    chk("rst_we",    32'(mem_we),  32'h0);
    chk("rst_be",    32'(mem_be),  32'h0);
    chk("rst_err",   32'(err),     32'h0);
    chk("rst_ld",    load_data,    32'h0);
    chk("rst_addr",  mem_addr,     32'h0);
    chk("rst_wdata", mem_wdata,    32'h0);
    rst = 1'b0;
    idle_inputs();
    tick();

    for (int i = 0; i < 14; i++) begin
      start      = 1'b1;
      is_store   = vec[i].st;
      funct3     = vec[i].f3;
      addr       = vec[i].a;
      store_data = vec[i].sd;
      tick();
      idle_inputs();
      if (vec[i].xerr == 2'b00) begin
        chk($sformatf("v%0d_req", i),  32'(mem_req), 32'h1);
        chk($sformatf("v%0d_busy", i), 32'(busy),    32'h1);
        chk($sformatf("v%0d_we", i),   32'(mem_we),  32'(vec[i].st));
        chk($sformatf("v%0d_addr", i), mem_addr,     vec[i].xaddr);
        chk($sformatf("v%0d_be", i),   32'(mem_be),  32'(vec[i].xbe));
        if (vec[i].st) chk($sformatf("v%0d_wdata", i), mem_wdata, vec[i].xwd);
        for (int k = 0; k < vec[i].dly; k++) begin
          tick();
          chk($sformatf("v%0d_hold_req", i), 32'(mem_req), 32'h1);
          chk($sformatf("v%0d_hold_be", i),  32'(mem_be),  32'(vec[i].xbe));
          chk($sformatf("v%0d_nodone", i),   32'(done),    32'h0);
        end
        mem_ack   = 1'b1;
        mem_rdata = vec[i].rd;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
      end else begin
        chk($sformatf("v%0d_noreq", i),  32'(mem_req), 32'h0);
        chk($sformatf("v%0d_nodone", i), 32'(done),    32'h0);
        tick();
        chk($sformatf("v%0d_noreq2", i), 32'(mem_req), 32'h0);
      end
      chk($sformatf("v%0d_done", i),   32'(done),    32'h1);
      chk($sformatf("v%0d_err", i),    32'(err),     32'(vec[i].xerr));
      chk($sformatf("v%0d_dbusy", i),  32'(busy),    32'h1);
      chk($sformatf("v%0d_dreq", i),   32'(mem_req), 32'h0);
      chk($sformatf("v%0d_dbe", i),    32'(mem_be),  32'h0);
      if (vec[i].xerr == 2'b00) chk($sformatf("v%0d_ld", i), load_data, vec[i].xld);
      tick();
      chk($sformatf("v%0d_pulse", i),  32'(done), 32'h0);
      chk($sformatf("v%0d_err0", i),   32'(err),  32'h0);
      chk($sformatf("v%0d_idle", i),   32'(busy), 32'h0);
      if (vec[i].xerr == 2'b00) chk($sformatf("v%0d_ldhold", i), load_data, vec[i].xld);
    end

    // Timeout: LHU with no ack
    begin
      int n;
      n = 0;
      start    = 1'b1;
      funct3   = 3'b101;
      addr     = 32'h0000_0010;
      tick();
      idle_inputs();
      chk("to_be", 32'(mem_be), 32'h3);
      while (mem_req && n < 40) begin
        n++;
        if (done) chk("to_early_done", 32'(done), 32'h0);
        tick();
      end
      chk("to_req_cycles", 32'(n),    32'd16);
      chk("to_done",       32'(done), 32'h1);
      chk("to_err",        32'(err),  32'h2);
      chk("to_ld",         load_data, 32'h0);
      tick();
      chk("to_pulse",      32'(done), 32'h0);
      chk("to_idle",       32'(busy), 32'h0);
    end

    // Stray ack while idle must not complete anything
    mem_ack = 1'b1;
    tick();
    chk("stray_done", 32'(done), 32'h0);
    tick();
    chk("stray_done2", 32'(done), 32'h0);
    chk("stray_busy",  32'(busy), 32'h0);
    mem_ack = 1'b0;

    // Reset during the third ACCESS cycle, with a start and an ack alongside it
    start  = 1'b1;
    funct3 = 3'b010;
    addr   = 32'h0000_0020;
    tick();
    idle_inputs();
    tick();
    tick();
    chk("ra_req_before", 32'(mem_req), 32'h1);
    rst     = 1'b1;
    start   = 1'b1;
    funct3  = 3'b010;
    addr    = 32'h0000_0020;
    mem_ack = 1'b1;
    tick();
    rst     = 1'b0;
    mem_ack = 1'b0;
    idle_inputs();
    chk("ra_req",  32'(mem_req), 32'h0);
    chk("ra_busy", 32'(busy),    32'h0);
    chk("ra_done", 32'(done),    32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ra_no_done", 32'(done), 32'h0);
      chk("ra_no_busy", 32'(busy), 32'h0);
    end

    // Fresh load after the abort completes normally
    start  = 1'b1;
    funct3 = 3'b010;
    addr   = 32'h0000_0020;
    tick();
    idle_inputs();
    chk("rn_req",  32'(mem_req), 32'h1);
    chk("rn_addr", mem_addr,     32'h0000_0020);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1122_3344;
    tick();
    mem_ack   = 1'b0;
    chk("rn_done", 32'(done), 32'h1);
    chk("rn_err",  32'(err),  32'h0);
    chk("rn_ld",   load_data, 32'h1122_3344);
    tick();
    chk("rn_pulse", 32'(done), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum cycles in ACCESS without mem_ack before abort (range 2..255).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request strobe from the execute stage
- is_store  in  1  1=store, 0=load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  effective address (ALU result)
- store_data  in  32  rs2 value
- busy  out  1  transaction in progress
- done  out  1  one-cycle completion pulse
- load_data  out  32  extended load result
- err  out  2  00 ok, 01 misaligned, 10 timeout, 11 illegal
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-replicated write data
- mem_ack  in  1  transfer complete; mem_rdata valid same cycle
- mem_rdata  in  32  read word
REQ-003 SHALL use one clock, clk; reset rst is synchronous and active-high.

Function
REQ-004 SHALL implement FSM IDLE -> ACCESS -> DONE -> IDLE, plus IDLE -> DONE on error.
REQ-005 SHALL capture is_store, funct3, addr, store_data only on start=1 in IDLE; start outside IDLE ignored.
REQ-006 SHALL flag illegal (err=11): funct3 in {011,110,111}, or store with funct3 in {100,101}.
REQ-007 SHALL flag misaligned (err=01): H/HU with addr[0]=1; W with addr[1:0]!=00; illegal has priority.
REQ-008 SHALL on error go IDLE -> DONE with no memory access; done asserts 2 cycles after start edge.
REQ-009 SHALL in ACCESS hold mem_req=1 and mem_addr, mem_we, mem_be, mem_wdata stable until mem_ack or timeout.
REQ-010 SHALL drive mem_addr = {addr[31:2],2'b00}.
REQ-011 SHALL drive mem_be: B 0001<<addr[1:0]; H 0011 (addr[1]=0) or 1100; W 1111; 0000 outside ACCESS.
REQ-012 SHALL drive mem_wdata: B {4{data[7:0]}}; H {2{data[15:0]}}; W data.
REQ-013 SHALL on load mem_ack register load_data: B/BU byte addr[1:0] sign/zero-extended; H/HU half addr[1] sign/zero-extended; W full word.
REQ-014 SHALL on store completion set load_data=0.
REQ-015 SHALL sample mem_ack only in ACCESS; ack in other states ignored.
REQ-016 SHALL count ACCESS cycles from 1; if count reaches TIMEOUT without ack, drop mem_req next cycle, enter DONE, err=10, load_data=0.
REQ-017 SHALL give ack-on-first-ACCESS-cycle latency: start at edge N, mem_req at N+1, done at N+2.
REQ-018 SHALL assert done exactly one cycle (in DONE); err valid that cycle only, 00 otherwise.
REQ-019 SHALL hold load_data from one done until the next done.
REQ-020 SHALL assert busy in ACCESS and DONE; busy=0 in IDLE.
REQ-021 SHALL register all outputs; none combinationally dependent on inputs.

Reset
REQ-022 SHALL on rst=1 at a clock edge enter IDLE; busy, done, mem_req, mem_we=0; mem_be=0000; err=00; load_data, mem_addr, mem_wdata, timeout counter=0.
REQ-023 SHALL abort an in-flight ACCESS on rst without done; mem_req low from the reset edge.
REQ-024 SHALL ignore start in the same cycle as rst=1.

Verification
REQ-025 LB, addr=0x00000103, mem_rdata=0x80FF1234, ack first ACCESS cycle -> mem_addr=0x00000100, mem_be=1000, done at N+2, load_data=0xFFFFFF80, err=00.
REQ-026 SH, addr=0x00000202, store_data=0x0000BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEFBEEF, load_data=0 at done.
REQ-027 LW, addr=0x00000006 -> no mem_req, done at N+2, err=01; funct3=011 -> err=11.
REQ-028 LHU, addr=0x00000010, mem_ack never asserts, TIMEOUT=16 -> mem_req high 16 cycles then low, done with err=10, load_data=0.
REQ-029 rst asserted in 3rd ACCESS cycle -> next cycle mem_req=0, busy=0, no done pulse; new start then completes normally.
